// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with oversampled bit recovery and a 4-deep history of good bytes.
// Outputs update one clk after the stop-bit mid-sample tick; there is no backpressure (push always succeeds).
module uart_rx_buffer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] RXBUF [3:0],
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [2:0] rx_count
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running divider; never realigned to the start edge.
  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_count  <= '0;
      for (int i = 0; i < 4; i++) RXBUF[i] <= 8'h00;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            scnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
              scnt <= '0;
              bcnt <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (scnt == SW'(OVERSAMPLE - 1)) begin
              shreg <= {rx_s, shreg[7:1]};
              scnt  <= '0;
              bcnt  <= bcnt + 1'b1;
              if (bcnt == 3'd7) state <= STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (scnt == SW'(OVERSAMPLE - 1)) begin
              scnt <= '0;
              if (rx_s) begin
                RXBUF[3] <= RXBUF[2];
                RXBUF[2] <= RXBUF[1];
                RXBUF[1] <= RXBUF[0];
                RXBUF[0] <= shreg;
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                rx_count <= (rx_count == 3'd4) ? 3'd4 : rx_count + 3'd1;
                state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
